// File: rtl/gpr_pkg.sv
// Shared types and constants for the 13-entry, 33-bit general-purpose register bank.
// Also holds the forwarding read used by the operand ports and the dump engine.
package gpr_pkg;
   localparam int DATA_W   = 33;
   localparam int NUM_REGS = 13;
   localparam int SEL_W    = 4;

   typedef logic [DATA_W-1:0] gpr_word_t;
   typedef logic [SEL_W-1:0]  gpr_sel_t;

   typedef enum logic [1:0] {IDLE, DUMP, DONE} dump_state_t;

   localparam gpr_sel_t NUM_SEL = SEL_W'(NUM_REGS);

   localparam gpr_sel_t R_A = 4'd0;
   localparam gpr_sel_t R_B = 4'd1;
   localparam gpr_sel_t R_C = 4'd2;
   localparam gpr_sel_t R_D = 4'd3;
   localparam gpr_sel_t R_E = 4'd4;
   localparam gpr_sel_t R_F = 4'd5;
   localparam gpr_sel_t R_G = 4'd6;
   localparam gpr_sel_t R_H = 4'd7;
   localparam gpr_sel_t R_I = 4'd8;
   localparam gpr_sel_t R_J = 4'd9;
   localparam gpr_sel_t R_K = 4'd10;
   localparam gpr_sel_t R_L = 4'd11;
   localparam gpr_sel_t R_M = 4'd12;

   // Write-first read: a same-cycle write to the selected index wins; unimplemented indices read 0.
   function automatic gpr_word_t gpr_read_fwd(input gpr_word_t [NUM_REGS-1:0] regs,
                                              input gpr_sel_t sel,
                                              input logic wr_en,
                                              input gpr_sel_t wr_sel,
                                              input gpr_word_t wr_data);
      gpr_word_t v;
      v = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sel == SEL_W'(i)) v = regs[i];
      end
      if (wr_en && (wr_sel == sel) && (sel < NUM_SEL)) v = wr_data;
      return v;
   endfunction
endpackage

// File: rtl/gpr_read_port.sv
// One registered GPR read port: 1-cycle latency, write-first forwarding, invalid-index flag.
module gpr_read_port
   import gpr_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  gpr_word_t [NUM_REGS-1:0]    regs,
   input  logic                        wr_en,
   input  gpr_sel_t                    wr_sel,
   input  gpr_word_t                   wr_data,
   input  logic                        rd_req,
   input  gpr_sel_t                    rd_sel,
   output gpr_word_t                   rd_data,
   output logic                        rd_valid,
   output logic                        rd_err
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         rd_err   <= rd_req && (rd_sel >= NUM_SEL);
         if (rd_req) rd_data <= gpr_read_fwd(regs, rd_sel, wr_en, wr_sel, wr_data);
      end
   end
endmodule

// File: rtl/gpr_bank_reader.sv
// GPR bank: write port, two operand read ports and a sequential dump engine.
//   state | meaning
//   IDLE  | waiting for dump_start
//   DUMP  | streaming one register per cycle, index 0..12
//   DONE  | dump_done pulse, then back to IDLE
module gpr_bank_reader
   import gpr_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [SEL_W-1:0]  wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_err,
   input  logic              rd_req_a,
   input  logic [SEL_W-1:0]  rd_sel_a,
   output logic [DATA_W-1:0] rd_data_a,
   output logic              rd_valid_a,
   output logic              rd_err_a,
   input  logic              rd_req_b,
   input  logic [SEL_W-1:0]  rd_sel_b,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_valid_b,
   output logic              rd_err_b,
   input  logic              dump_start,
   output logic              dump_busy,
   output logic              dump_valid,
   output logic [SEL_W-1:0]  dump_idx,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_done
);
   gpr_word_t [NUM_REGS-1:0] regs;
   dump_state_t              state, state_nx;
   gpr_sel_t                 cnt, cnt_nx, idx_nx;
   gpr_word_t                data_nx;
   logic                     valid_nx, done_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs   <= '0;
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en && (wr_sel >= NUM_SEL);
         if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (wr_sel == SEL_W'(i)) regs[i] <= wr_data;
            end
         end
      end
   end

   gpr_read_port u_port_a (
      .clk(clk), .rst_n(rst_n), .regs(regs),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .rd_req(rd_req_a), .rd_sel(rd_sel_a),
      .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_err(rd_err_a)
   );

   gpr_read_port u_port_b (
      .clk(clk), .rst_n(rst_n), .regs(regs),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .rd_req(rd_req_b), .rd_sel(rd_sel_b),
      .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_err(rd_err_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         dump_valid <= 1'b0;
         dump_idx   <= '0;
         dump_data  <= '0;
         dump_done  <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         dump_valid <= valid_nx;
         dump_idx   <= idx_nx;
         dump_data  <= data_nx;
         dump_done  <= done_nx;
      end
   end

   // cnt runs one ahead of dump_idx because outputs are registered from the next-state values.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      valid_nx = 1'b0;
      idx_nx   = dump_idx;
      data_nx  = dump_data;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (dump_start) begin
               state_nx = DUMP;
               valid_nx = 1'b1;
               idx_nx   = '0;
               data_nx  = gpr_read_fwd(regs, '0, wr_en, wr_sel, wr_data);
               cnt_nx   = SEL_W'(1);
            end
         end
         DUMP: begin
            if (cnt == NUM_SEL) begin
               state_nx = DONE;
               done_nx  = 1'b1;
               cnt_nx   = '0;
            end else begin
               valid_nx = 1'b1;
               idx_nx   = cnt;
               data_nx  = gpr_read_fwd(regs, cnt, wr_en, wr_sel, wr_data);
               cnt_nx   = cnt + 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign dump_busy = (state != IDLE);
endmodule

// File: tb/tb_gpr_bank_reader.sv
// Directed bench for gpr_bank_reader: vector table for read/write ports, sequences for dump and reset.
module tb_gpr_bank_reader;
   localparam int DW = 33;

   logic          clk, rst_n;
   logic          wr_en;
   logic [3:0]    wr_sel;
   logic [DW-1:0] wr_data;
   logic          wr_err;
   logic          rd_req_a, rd_req_b;
   logic [3:0]    rd_sel_a, rd_sel_b;
   logic [DW-1:0] rd_data_a, rd_data_b;
   logic          rd_valid_a, rd_valid_b, rd_err_a, rd_err_b;
   logic          dump_start, dump_busy, dump_valid, dump_done;
   logic [3:0]    dump_idx;
   logic [DW-1:0] dump_data;

   int checks = 0;
   int failures = 0;

   gpr_bank_reader dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wr_err(wr_err),
      .rd_req_a(rd_req_a), .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a),
      .rd_valid_a(rd_valid_a), .rd_err_a(rd_err_a),
      .rd_req_b(rd_req_b), .rd_sel_b(rd_sel_b), .rd_data_b(rd_data_b),
      .rd_valid_b(rd_valid_b), .rd_err_b(rd_err_b),
      .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
      .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          wr_en;
      logic [3:0]    wr_sel;
      logic [DW-1:0] wr_data;
      logic          req_a;
      logic [3:0]    sel_a;
      logic          req_b;
      logic [3:0]    sel_b;
      logic          va;
      logic [DW-1:0] da;
      logic          ea;
      logic          vb;
      logic [DW-1:0] db;
      logic          eb;
      logic          werr;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_sel = '0; wr_data = '0;
      rd_req_a = 1'b0; rd_sel_a = '0; rd_req_b = 1'b0; rd_sel_b = '0;
      dump_start = 1'b0;
   endtask

   task automatic write_reg(input logic [3:0] sel, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_sel = sel; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wr_err"}, 64'(wr_err), 64'd0);
      chk({tag, "_rd_a"}, {30'd0, rd_data_a, rd_valid_a}, 64'd0);
      chk({tag, "_rd_b"}, {30'd0, rd_data_b, rd_valid_b}, 64'd0);
      chk({tag, "_err_ab"}, {62'd0, rd_err_a, rd_err_b}, 64'd0);
      chk({tag, "_dump_ctl"}, {60'd0, dump_busy, dump_valid, dump_done, 1'b0}, 64'd0);
      chk({tag, "_dump_data"}, {27'd0, dump_data, dump_idx}, 64'd0);
   endtask

   initial begin
      int cyc;
      int n_valid;
      bit saw_done;

      vecs[0]  = '{0, 0,  0,             1, 0,  1, 12, 1, 0,             0, 1, 0,             0, 0};
      vecs[1]  = '{1, 3,  501,           0, 0,  0, 0,  0, 0,             0, 0, 0,             0, 0};
      vecs[2]  = '{0, 0,  0,             1, 3,  0, 0,  1, 501,           0, 0, 0,             0, 0};
      vecs[3]  = '{1, 3,  502,           0, 0,  1, 3,  0, 501,           0, 1, 502,           0, 0};
      vecs[4]  = '{0, 0,  0,             1, 3,  0, 0,  1, 502,           0, 0, 502,           0, 0};
      vecs[5]  = '{1, 13, 501,           0, 0,  0, 0,  0, 502,           0, 0, 502,           0, 1};
      vecs[6]  = '{1, 14, 501,           1, 15, 0, 0,  1, 0,             1, 0, 502,           0, 1};
      vecs[7]  = '{1, 15, 501,           0, 0,  1, 13, 0, 0,             0, 1, 0,             1, 1};
      vecs[8]  = '{0, 0,  0,             1, 0,  1, 3,  1, 0,             0, 1, 502,           0, 0};
      vecs[9]  = '{1, 0,  33'h1FFFFFFFF, 1, 0,  1, 0,  1, 33'h1FFFFFFFF, 0, 1, 33'h1FFFFFFFF, 0, 0};
      vecs[10] = '{1, 12, 33'h100000001, 1, 12, 1, 11, 1, 33'h100000001, 0, 1, 0,             0, 0};
      vecs[11] = '{0, 0,  0,             1, 12, 1, 0,  1, 33'h100000001, 0, 1, 33'h1FFFFFFFF, 0, 0};

      idle_inputs();
      rst_n = 1'b0;
      #12;
      chk_all_zero("reset");
      step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 12; i++) begin
         wr_en = vecs[i].wr_en; wr_sel = vecs[i].wr_sel; wr_data = vecs[i].wr_data;
         rd_req_a = vecs[i].req_a; rd_sel_a = vecs[i].sel_a;
         rd_req_b = vecs[i].req_b; rd_sel_b = vecs[i].sel_b;
         step();
         chk($sformatf("v%0d_valid_a", i), 64'(rd_valid_a), 64'(vecs[i].va));
         chk($sformatf("v%0d_data_a", i), 64'(rd_data_a), 64'(vecs[i].da));
         chk($sformatf("v%0d_err_a", i), 64'(rd_err_a), 64'(vecs[i].ea));
         chk($sformatf("v%0d_valid_b", i), 64'(rd_valid_b), 64'(vecs[i].vb));
         chk($sformatf("v%0d_data_b", i), 64'(rd_data_b), 64'(vecs[i].db));
         chk($sformatf("v%0d_err_b", i), 64'(rd_err_b), 64'(vecs[i].eb));
         chk($sformatf("v%0d_wr_err", i), 64'(wr_err), 64'(vecs[i].werr));
      end
      idle_inputs();
      step();
      chk("wr_err_cleared", 64'(wr_err), 64'd0);

      // Full dump with a mid-dump restart attempt and a forwarded write to index 7
      for (int i = 0; i < 13; i++) write_reg(4'(i), DW'(500 + i));
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      for (int k = 0; k < 13; k++) begin
         chk($sformatf("dump%0d_valid", k), 64'(dump_valid), 64'd1);
         chk($sformatf("dump%0d_idx", k), 64'(dump_idx), 64'(k));
         chk($sformatf("dump%0d_data", k), 64'(dump_data), (k == 7) ? 64'd777 : 64'(500 + k));
         chk($sformatf("dump%0d_busy_done", k), {62'd0, dump_busy, dump_done}, 64'd2);
         dump_start = (k == 4);
         wr_en = (k == 6); wr_sel = 4'd7; wr_data = 33'd777;
         step();
      end
      idle_inputs();
      chk("dump_done_pulse", {61'd0, dump_busy, dump_valid, dump_done}, 64'b101);
      step();
      chk("dump_done_end", {61'd0, dump_busy, dump_valid, dump_done}, 64'b000);
      step();
      chk("dump_no_restart", 64'(dump_busy), 64'd0);

      // Reset in the middle of a dump
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      cyc = 0;
      while (!(dump_valid && dump_idx == 4'd5) && cyc < 30) begin
         step();
         cyc++;
      end
      chk("abort_reached_idx5", 64'(cyc < 30), 64'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("abort");
      step();
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (dump_done || dump_busy) saw_done = 1'b1;
      end
      chk("abort_no_done", 64'(saw_done), 64'd0);
      rd_req_a = 1'b1; rd_sel_a = 4'd7;
      rd_req_b = 1'b1; rd_sel_b = 4'd12;
      step();
      idle_inputs();
      chk("abort_reg7_cleared", {31'd0, rd_data_a, rd_valid_a}, 64'd1);
      chk("abort_reg12_cleared", {31'd0, rd_data_b, rd_valid_b}, 64'd1);

      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      n_valid = 0;
      cyc = 0;
      while (!dump_done && cyc < 40) begin
         if (dump_valid) begin
            chk($sformatf("redump%0d_idx", n_valid), 64'(dump_idx), 64'(n_valid));
            chk($sformatf("redump%0d_data", n_valid), 64'(dump_data), 64'd0);
            n_valid++;
         end
         step();
         cyc++;
      end
      chk("redump_done_seen", 64'(dump_done), 64'd1);
      chk("redump_valid_count", 64'(n_valid), 64'd13);
      step();

      // Back-to-back port A reads
      for (int i = 0; i < 13; i++) write_reg(4'(i), DW'(1000 + 7 * i));
      for (int i = 0; i < 13; i++) begin
         rd_req_a = 1'b1; rd_sel_a = 4'(i);
         step();
         chk($sformatf("b2b%0d_valid", i), 64'(rd_valid_a), 64'd1);
         chk($sformatf("b2b%0d_data", i), 64'(rd_data_a), 64'(1000 + 7 * i));
      end
      idle_inputs();
      step();
      chk("b2b_valid_drop", 64'(rd_valid_a), 64'd0);
      chk("b2b_data_hold", 64'(rd_data_a), 64'd1084);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
